// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard unit with multi-cycle execute ops, memory wait stalls and stall counter
// Forwarding, prioritised stall/flush generation, long-op FSM and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              resultsrcE,
  input  logic              pcsrcE,
  input  logic [1:0]        longopE,
  input  logic              memreqM,
  input  logic              dmem_readyM,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic w_memstall;
  logic w_longop_valid;
  logic w_longop_stall;
  logic w_loaduse;

  assign w_memstall     = memreqM && !dmem_readyM;
  assign w_longop_valid = (longopE == 2'b01) || (longopE == 2'b10);
  assign w_longop_stall = ((r_state == S_IDLE) && w_longop_valid) ||
                          ((r_state == S_BUSY) && (r_cnt != '0));
  assign w_loaduse      = resultsrcE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  always_comb begin
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    if (!rst_n) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      if (regwriteM && (rdM != '0) && (rdM == rs1E))      forwardaE = 2'b10;
      else if (regwriteW && (rdW != '0) && (rdW == rs1E)) forwardaE = 2'b01;
      if (regwriteM && (rdM != '0) && (rdM == rs2E))      forwardbE = 2'b10;
      else if (regwriteW && (rdW != '0) && (rdW == rs2E)) forwardbE = 2'b01;

      // Priority chain: a higher hazard masks every lower one.
      if (w_memstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (w_longop_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (pcsrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (w_loaduse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      // A memory stall freezes E, so the long-op sequence must freeze with it.
      if (!w_memstall) begin
        case (r_state)
          S_IDLE: begin
            if (w_longop_valid) begin
              r_cnt   <= (longopE == 2'b10) ? DIV_LOAD : MUL_LOAD;
              r_state <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            else             r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (stallF && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign busy         = (r_state == S_BUSY);
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - self-checking bench for hazard_unit_mc against a cycle-level reference model
module tb_hazard_unit_mc;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteM, regwriteW, resultsrcE, pcsrcE, memreqM, dmem_readyM;
  logic [1:0] longopE;

  logic [1:0]  forwardaE, forwardbE;
  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, busy;
  logic [31:0] stall_cycles;

  logic [1:0]  s_forwardaE, s_forwardbE;
  logic        s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushM, s_flushW, s_busy;
  logic [3:0]  s_stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: long op in flight, E cycles it has consumed, its latency, total stalled cycles
  bit      m_active = 0;
  int      m_done   = 0;
  int      m_lat    = 0;
  longint  m_sc     = 0;
  bit      ms, lv;
  logic [1:0] e_fa, e_fb;
  logic    e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fW;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW), .resultsrcE(resultsrcE),
    .pcsrcE(pcsrcE), .longopE(longopE), .memreqM(memreqM), .dmem_readyM(dmem_readyM),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .flushW(flushW), .busy(busy), .stall_cycles(stall_cycles));

  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW), .resultsrcE(resultsrcE),
    .pcsrcE(pcsrcE), .longopE(longopE), .memreqM(memreqM), .dmem_readyM(dmem_readyM),
    .forwardaE(s_forwardaE), .forwardbE(s_forwardbE), .stallF(s_stallF), .stallD(s_stallD),
    .stallE(s_stallE), .stallM(s_stallM), .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM),
    .flushW(s_flushW), .busy(s_busy), .stall_cycles(s_stall_cycles));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    rst_n = 1; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regwriteM = 0; regwriteW = 0; resultsrcE = 0; pcsrcE = 0; longopE = 0;
    memreqM = 0; dmem_readyM = 1;
  endtask

  // Mid-cycle: compare the combinational outputs against the model.
  task automatic mid();
    bit lo, lu;
    #3;
    ms = memreqM && !dmem_readyM;
    lv = (longopE == 2'b01) || (longopE == 2'b10);
    lo = (!m_active && lv) || (m_active && m_done < m_lat - 1);
    lu = resultsrcE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    {e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fW} = '0;
    e_fa = 2'b00; e_fb = 2'b00;
    if (!rst_n) begin
      {e_fD, e_fE, e_fM, e_fW} = 4'b1111;
    end else begin
      e_fa = fwd(rs1E);
      e_fb = fwd(rs2E);
      if (ms)          {e_sF, e_sD, e_sE, e_sM, e_fW} = 5'b11111;
      else if (lo)     {e_sF, e_sD, e_sE, e_fM} = 4'b1111;
      else if (pcsrcE) {e_fD, e_fE} = 2'b11;
      else if (lu)     {e_sF, e_sD, e_fE} = 3'b111;
    end
    check_eq("forwardaE", 32'(forwardaE), 32'(e_fa));
    check_eq("forwardbE", 32'(forwardbE), 32'(e_fb));
    check_eq("stalls", 32'({stallF, stallD, stallE, stallM}), 32'({e_sF, e_sD, e_sE, e_sM}));
    check_eq("flushes", 32'({flushD, flushE, flushM, flushW}), 32'({e_fD, e_fE, e_fM, e_fW}));
    check_eq("sat_stalls", 32'({s_stallF, s_stallE, s_flushW}), 32'({e_sF, e_sE, e_fW}));
  endtask

  // Clock edge: advance the model, then compare the registered outputs.
  task automatic tick();
    if (!rst_n) begin
      m_active = 0;
      m_sc = 0;
    end else begin
      if (e_sF) m_sc++;
      if (!ms) begin
        if (!m_active && lv) begin
          m_active = 1;
          m_done = 1;
          m_lat = (longopE == 2'b10) ? DIV_LAT : MUL_LAT;
        end else if (m_active) begin
          if (m_done < m_lat - 1) m_done++;
          else m_active = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("stall_cycles", stall_cycles, 32'(m_sc));
    check_eq("sat_stall_cycles", 32'(s_stall_cycles), (m_sc > 15) ? 32'd15 : 32'(m_sc));
  endtask

  task automatic step();
    mid();
    tick();
  endtask

  initial begin
    int rel;
    clear_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    step(); step();
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_stall_cycles", stall_cycles, 32'd0);
    rst_n = 1;

    // forwarding
    regwriteM = 1; rdM = 5; regwriteW = 1; rdW = 5; rs1E = 5; rs2E = 0;
    mid();
    check_eq("fwd_a_M", 32'(forwardaE), 32'd2);
    check_eq("fwd_b_none", 32'(forwardbE), 32'd0);
    tick();
    regwriteM = 0;
    mid(); check_eq("fwd_a_W", 32'(forwardaE), 32'd1); tick();
    regwriteM = 1; rdM = 0; regwriteW = 0; rs1E = 0;
    mid(); check_eq("fwd_rd0", 32'(forwardaE), 32'd0); tick();

    // load-use
    clear_inputs();
    resultsrcE = 1; rdE = 7; rs2D = 7;
    mid(); check_eq("loaduse_stall", 32'({stallF, stallD, flushE}), 32'b111); tick();
    check_eq("loaduse_count", stall_cycles, 32'd1);
    rdE = 0; rs2D = 0;
    mid(); check_eq("loaduse_rd0", 32'(stallF), 32'd0); tick();

    // multiply: two stall cycles then release
    clear_inputs();
    longopE = 2'b01;
    mid(); check_eq("mul_c1", 32'({stallE, flushM}), 32'b11); tick();
    check_eq("mul_busy_c2", 32'(busy), 32'd1);
    mid(); check_eq("mul_c2", 32'({stallE, flushM}), 32'b11); tick();
    mid(); check_eq("mul_c3", 32'(stallE), 32'd0); tick();
    longopE = 2'b00;
    step();

    // divide with two memstall cycles inside BUSY
    longopE = 2'b10;
    rel = 20;
    for (int c = 0; c < 20; c++) begin
      memreqM = (c == 3 || c == 4);
      dmem_readyM = 0;
      mid();
      if (c == 3) check_eq("div_memstall", 32'({stallM, flushW, flushM}), 32'b110);
      if (!stallE) begin
        rel = c;
        tick();
        break;
      end
      tick();
    end
    check_eq("div_release_cycle", rel, 32'd9);
    clear_inputs();
    step();

    // redirect versus load-use, then redirect deferred by memstall
    pcsrcE = 1; resultsrcE = 1; rdE = 7; rs1D = 7;
    mid(); check_eq("redir_lu", 32'({flushD, flushE, stallF}), 32'b110); tick();
    memreqM = 1; dmem_readyM = 0;
    mid(); check_eq("redir_deferred", 32'(flushD), 32'd0); tick();
    dmem_readyM = 1;
    mid(); check_eq("redir_after", 32'(flushD), 32'd1); tick();

    // reset in the middle of a divide
    clear_inputs();
    longopE = 2'b10;
    step(); step();
    regwriteM = 1; rdM = 3; rs1E = 3; rst_n = 0;
    mid(); check_eq("rst_forced", 32'({stallF, stallE, flushD, flushW, forwardaE}), 32'b001100); tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1; longopE = 2'b00;
    mid(); check_eq("rst_no_residual", 32'(stallE), 32'd0); tick();

    // saturation of the narrow counter
    clear_inputs();
    resultsrcE = 1; rdE = 4; rs1D = 4;
    for (int i = 0; i < 20; i++) step();
    check_eq("sat_15", 32'(s_stall_cycles), 32'd15);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      rs1D        = 5'($urandom_range(0, 3));
      rs2D        = 5'($urandom_range(0, 3));
      rs1E        = 5'($urandom_range(0, 3));
      rs2E        = 5'($urandom_range(0, 3));
      rdE         = 5'($urandom_range(0, 3));
      rdM         = 5'($urandom_range(0, 3));
      rdW         = 5'($urandom_range(0, 3));
      regwriteM   = 1'($urandom_range(0, 1));
      regwriteW   = 1'($urandom_range(0, 1));
      resultsrcE  = 1'($urandom_range(0, 1));
      pcsrcE      = ($urandom_range(0, 3) == 0);
      longopE     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      memreqM     = ($urandom_range(0, 2) == 0);
      dmem_readyM = 1'($urandom_range(0, 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised pipeline hazard unit for the 5-stage core, replacing the single-cycle forwarding and stall logic. It adds three things: multi-cycle execute operations (mul/div held in E by an internal FSM and counter), data-memory wait-state stalls, and a saturating stall-cycle performance counter. It sits beside the pipeline registers and drives their stall and flush enables plus the E-stage operand-forwarding muxes.

## Interface
Parameters:
- REG_AW, 5, register address width
- MUL_LAT, 3, total E-stage cycles for a multiply (must be ≥2)
- DIV_LAT, 8, total E-stage cycles for a divide (must be ≥2)
- CNT_W, 32, width of the stall_cycles counter

Ports:
- clk  in  1  single core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- rs1D, rs2D  in  REG_AW  source registers in D
- rs1E, rs2E, rdE  in  REG_AW  source and destination registers in E
- rdM, rdW  in  REG_AW  destination registers in M and W
- regwriteM, regwriteW  in  1  register write enables in M and W
- resultsrcE  in  1  E instruction is a load
- pcsrcE  in  1  taken branch or jump redirect from E
- longopE  in  2  E operation class: 00 none, 01 mul, 10 div, 11 reserved (treat as none)
- memreqM  in  1  M instruction accesses data memory
- dmem_readyM  in  1  data memory completes the access this cycle
- forwardaE, forwardbE  out  2  00 register file, 01 W result, 10 M ALU result
- stallF, stallD, stallE, stallM  out  1  hold the corresponding pipeline register
- flushD, flushE, flushM, flushW  out  1  insert a bubble into the corresponding pipeline register
- busy  out  1  long-op FSM is in BUSY
- stall_cycles  out  CNT_W  count of cycles with stallF=1, saturating

## Operation
Forwarding (combinational, always active, including during stalls):
- A operand: forwardaE=10 if regwriteM && rdM≠0 && rdM==rs1E; else 01 if regwriteW && rdW≠0 && rdW==rs1E; else 00.
- B operand: same rule using rs2E.
- M has priority over W.

Hazards are evaluated in priority order; a higher-priority hazard masks every lower one.
- P1, memory stall (memstall = memreqM && !dmem_readyM):
  - stallF, stallD, stallE, stallM = 1; flushW = 1; all other flushes = 0.
  - FSM state and counter hold.
- P2, long op, when longopE∈{01,10} with state IDLE, or state BUSY with cnt≠0:
  - stallF, stallD, stallE = 1; flushM = 1.
- P3, redirect (pcsrcE): flushD = 1, flushE = 1, no stalls.
- P4, load-use (resultsrcE && rdE≠0 && (rdE==rs1D || rdE==rs2D)): stallF = 1, stallD = 1, flushE = 1.
- Otherwise all stalls and flushes are 0.

Long-op FSM (states IDLE, BUSY; cnt width $clog2(max(MUL_LAT,DIV_LAT))):
- IDLE: if longopE valid and !memstall, load cnt = LAT−2 (LAT = MUL_LAT or DIV_LAT) and go to BUSY.
- BUSY, cnt≠0, !memstall: cnt decrements.
- BUSY, cnt==0, !memstall: no long-op stall this cycle; the instruction advances to M; next state IDLE.
- Any memstall: hold state and cnt.
- Result: a long op occupies E for exactly LAT cycles when there is no memstall, plus one cycle per memstall cycle.

Performance counter:
- stall_cycles increments on each cycle with stallF=1.
- It saturates at all-ones.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - state = IDLE, cnt = 0, stall_cycles = 0.
  - While rst_n=0 the outputs are forced: all stalls 0, flushD/E/M/W = 1, forward outputs 00, busy 0.
- Stall, flush and forward outputs are combinational from inputs and state, valid in the same cycle.
- busy and stall_cycles are registered.
- Reset asserted mid long-op: the FSM returns to IDLE at the next edge; no residual stall after rst_n rises.
- pcsrcE during memstall: the redirect is deferred. E is frozen, so pcsrcE is still present when memstall clears, and the flush occurs then.
- Load-use coincident with redirect: flush only; no stall.
- Back-to-back long ops: the second enters E in the cycle after BUSY/cnt==0 and is seen in IDLE, so it restarts with no gap cycle.

## Test plan
- Forwarding: regwriteM=1, rdM=5, regwriteW=1, rdW=5, rs1E=5, rs2E=0 -> forwardaE=10, forwardbE=00. Then regwriteM=0 -> forwardaE=01. rdM=0 never forwards.
- Load-use: resultsrcE=1, rdE=7, rs2D=7 -> stallF=stallD=flushE=1 for one cycle, stall_cycles +1. Same with rdE=0 -> no stall.
- Multiply: longopE=01 held, MUL_LAT=3 -> stallE=1 and flushM=1 for cycles 1–2, released in cycle 3, busy=1 in cycles 2–3. Divide with DIV_LAT=8 -> 7 stall cycles.
- Memstall inside a divide: memreqM=1, dmem_readyM=0 for 2 cycles during BUSY -> stallM=flushW=1 and cnt frozen; the divide releases 2 cycles later than nominal.
- Redirect versus load-use: pcsrcE=1 together with a load-use match -> flushD=flushE=1, stallF=0. Then pcsrcE=1 during memstall -> no flushD until dmem_readyM=1.
- Reset and saturation: assert rst_n=0 during BUSY -> IDLE, outputs forced as specified. With CNT_W=4 and 20 stalled cycles -> stall_cycles=15.
